// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle for data_mem_ctrl: byte-addressed load/store
// requests with a valid/ready handshake, plus load response and status.
interface data_mem_ctrl_if #(parameter int ADDR_W = 7);
  logic              ReqValid;
  logic              ReqReady;
  logic              ReqWrite;
  logic [1:0]        ReqSize;
  logic              ReqSigned;
  logic [ADDR_W-1:0] Address;
  logic [31:0]       WriteData;
  logic              RespValid;
  logic [31:0]       ReadData;
  logic              Misaligned;
  logic              InitDone;

  modport slave (
    input  ReqValid, ReqWrite, ReqSize, ReqSigned, Address, WriteData,
    output ReqReady, RespValid, ReadData, Misaligned, InitDone
  );

  modport master (
    output ReqValid, ReqWrite, ReqSize, ReqSigned, Address, WriteData,
    input  ReqReady, RespValid, ReadData, Misaligned, InitDone
  );
endinterface

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory: byte/half/word loads and stores, sign/zero extension,
// READ_LAT-deep read pipeline, misalignment detection, clear-on-reset pass.
module data_mem_ctrl #(
  parameter  int DEPTH    = 32,
  parameter  int READ_LAT = 1,
  localparam int IDX_W    = $clog2(DEPTH),
  localparam int ADDR_W   = IDX_W + 2
) (
  input logic          clk,
  input logic          reset,
  data_mem_ctrl_if.slave bus
);

  typedef enum logic {S_INIT, S_IDLE} state_t;

  typedef struct packed {
    logic [31:0] word;
    logic [1:0]  lane;
    logic [1:0]  size;
    logic        sgn;
  } rd_t;

  state_t           r_state, w_state_nxt;
  logic [IDX_W-1:0] r_init_idx;
  logic [31:0]      r_mem [DEPTH];

  logic [READ_LAT:1] r_vld_pipe;
  logic [31:0]       r_rdata;
  logic              r_mis;

  logic             w_rdy, w_acc, w_bad, w_ld_acc, w_st_acc, w_fin_vld;
  logic [IDX_W-1:0] w_idx;
  logic [1:0]       w_lane;
  logic [3:0]       w_be;
  logic [31:0]      w_wlanes, w_ext;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  rd_t              w_src, w_fin;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_INIT;
      r_init_idx <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_INIT) r_init_idx <= r_init_idx + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_INIT && r_init_idx == IDX_W'(DEPTH - 1)) w_state_nxt = S_IDLE;
  end

  assign w_rdy    = (r_state == S_IDLE);
  assign w_idx    = bus.Address[ADDR_W-1:2];
  assign w_lane   = bus.Address[1:0];
  assign w_acc    = bus.ReqValid & w_rdy;
  assign w_bad    = (bus.ReqSize == 2'b11) ||
                    (bus.ReqSize == 2'b01 && w_lane[0]) ||
                    (bus.ReqSize == 2'b10 && w_lane != 2'b00);
  assign w_ld_acc = w_acc & ~bus.ReqWrite & ~w_bad;
  assign w_st_acc = w_acc &  bus.ReqWrite & ~w_bad;

  // Replicate store data across lanes so every enabled lane picks its own slice
  always_comb begin
    w_be     = 4'b1111;
    w_wlanes = bus.WriteData;
    case (bus.ReqSize)
      2'b00: begin
        w_be     = 4'b0001 << w_lane;
        w_wlanes = {4{bus.WriteData[7:0]}};
      end
      2'b01: begin
        w_be     = 4'b0011 << w_lane;
        w_wlanes = {2{bus.WriteData[15:0]}};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (r_state == S_INIT) begin
      r_mem[r_init_idx] <= '0;
    end else if (w_st_acc) begin
      for (int k = 0; k < 4; k++)
        if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wlanes[8*k +: 8];
    end
  end

  // Word is captured at accept; later stores cannot disturb an in-flight load
  assign w_src = {r_mem[w_idx], w_lane, bus.ReqSize, bus.ReqSigned};

  generate
    if (READ_LAT == 1) begin : g_direct
      assign w_fin     = w_src;
      assign w_fin_vld = w_ld_acc;
    end else begin : g_pipe
      rd_t r_stg [1:READ_LAT-1];
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int k = 1; k < READ_LAT; k++) r_stg[k] <= '0;
        end else begin
          r_stg[1] <= w_src;
          for (int k = 2; k < READ_LAT; k++) r_stg[k] <= r_stg[k-1];
        end
      end
      assign w_fin     = r_stg[READ_LAT-1];
      assign w_fin_vld = r_vld_pipe[READ_LAT-1];
    end
  endgenerate

  always_comb begin
    w_byte = w_fin.word[8*w_fin.lane +: 8];
    w_half = w_fin.lane[1] ? w_fin.word[31:16] : w_fin.word[15:0];
    case (w_fin.size)
      2'b00:   w_ext = {{24{w_fin.sgn & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{w_fin.sgn & w_half[15]}}, w_half};
      default: w_ext = w_fin.word;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_rdata    <= '0;
      r_mis      <= 1'b0;
    end else begin
      r_vld_pipe[1] <= w_ld_acc;
      for (int k = 2; k <= READ_LAT; k++) r_vld_pipe[k] <= r_vld_pipe[k-1];
      if (w_fin_vld) r_rdata <= w_ext;
      r_mis <= w_acc & w_bad;
    end
  end

  assign bus.ReqReady   = w_rdy;
  assign bus.InitDone   = w_rdy;
  assign bus.RespValid  = r_vld_pipe[READ_LAT];
  assign bus.ReadData   = r_rdata;
  assign bus.Misaligned = r_mis;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: READ_LAT=1 and READ_LAT=3 instances,
// directed stimulus pushes expectations, negedge monitors pop and compare.
module tb_data_mem_ctrl;
  localparam int DEPTH = 32;
  localparam int AW    = $clog2(DEPTH) + 2;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  data_mem_ctrl_if #(.ADDR_W(AW)) if1 ();
  data_mem_ctrl_if #(.ADDR_W(AW)) if3 ();

  data_mem_ctrl #(.DEPTH(DEPTH), .READ_LAT(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));
  data_mem_ctrl #(.DEPTH(DEPTH), .READ_LAT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3.slave));

  typedef struct { int cyc; logic [31:0] data; } exp_t;
  exp_t rq1[$], rq3[$];
  int   mq1[$], mq3[$];
  int   n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic fail(input string nm, input int act, input int exp);
    n_chk++;
    $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    int   m;
    if (if1.RespValid) begin
      if (rq1.size() == 0) fail("resp1_unexpected", cyc, -1);
      else begin
        e = rq1.pop_front();
        chk("resp1_cycle", cyc, e.cyc);
        chk("resp1_data", if1.ReadData, e.data);
      end
    end else if (rq1.size() > 0 && rq1[0].cyc <= cyc) begin
      e = rq1.pop_front();
      fail("resp1_missing", cyc, e.cyc);
    end
    if (if1.Misaligned) begin
      if (mq1.size() == 0) fail("mis1_unexpected", cyc, -1);
      else begin m = mq1.pop_front(); chk("mis1_cycle", cyc, m); end
    end else if (mq1.size() > 0 && mq1[0] <= cyc) begin
      m = mq1.pop_front();
      fail("mis1_missing", cyc, m);
    end
  end

  always @(negedge clk) begin : mon3
    exp_t e;
    int   m;
    if (if3.RespValid) begin
      if (rq3.size() == 0) fail("resp3_unexpected", cyc, -1);
      else begin
        e = rq3.pop_front();
        chk("resp3_cycle", cyc, e.cyc);
        chk("resp3_data", if3.ReadData, e.data);
      end
    end else if (rq3.size() > 0 && rq3[0].cyc <= cyc) begin
      e = rq3.pop_front();
      fail("resp3_missing", cyc, e.cyc);
    end
    if (if3.Misaligned) begin
      if (mq3.size() == 0) fail("mis3_unexpected", cyc, -1);
      else begin m = mq3.pop_front(); chk("mis3_cycle", cyc, m); end
    end else if (mq3.size() > 0 && mq3[0] <= cyc) begin
      m = mq3.pop_front();
      fail("mis3_missing", cyc, m);
    end
  end

  // Drives one request for a single edge; called #1 after a rising edge
  task automatic req(input int sel, input bit wr, input logic [1:0] sz, input bit sg,
                     input logic [AW-1:0] a, input logic [31:0] wd,
                     input bit mis, input bit trk, input logic [31:0] ed);
    exp_t e;
    e.cyc  = cyc + ((sel == 1) ? 1 : 3);
    e.data = ed;
    if (sel == 1) begin
      if1.ReqValid = 1'b1; if1.ReqWrite = wr; if1.ReqSize = sz;
      if1.ReqSigned = sg; if1.Address = a; if1.WriteData = wd;
      chk("ready1", {31'b0, if1.ReqReady}, 32'd1);
      if (mis) mq1.push_back(cyc + 1);
      else if (!wr && trk) rq1.push_back(e);
    end else begin
      if3.ReqValid = 1'b1; if3.ReqWrite = wr; if3.ReqSize = sz;
      if3.ReqSigned = sg; if3.Address = a; if3.WriteData = wd;
      chk("ready3", {31'b0, if3.ReqReady}, 32'd1);
      if (mis) mq3.push_back(cyc + 1);
      else if (!wr && trk) rq3.push_back(e);
    end
    @(posedge clk); #1;
    if (sel == 1) if1.ReqValid = 1'b0;
    else          if3.ReqValid = 1'b0;
  endtask

  task automatic ld(input int sel, input logic [1:0] sz, input bit sg,
                    input logic [AW-1:0] a, input logic [31:0] ed);
    req(sel, 1'b0, sz, sg, a, 32'h0, 1'b0, 1'b1, ed);
  endtask

  task automatic st(input int sel, input logic [1:0] sz, input logic [AW-1:0] a,
                    input logic [31:0] wd);
    req(sel, 1'b1, sz, 1'b0, a, wd, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic bad(input int sel, input bit wr, input logic [1:0] sz,
                     input logic [AW-1:0] a, input logic [31:0] wd);
    req(sel, wr, sz, 1'b0, a, wd, 1'b1, 1'b0, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic reset_checks();
    chk("rst_ready1", {31'b0, if1.ReqReady},   32'd0);
    chk("rst_rv1",    {31'b0, if1.RespValid},  32'd0);
    chk("rst_rd1",    if1.ReadData,            32'd0);
    chk("rst_mis1",   {31'b0, if1.Misaligned}, 32'd0);
    chk("rst_done1",  {31'b0, if1.InitDone},   32'd0);
    chk("rst_ready3", {31'b0, if3.ReqReady},   32'd0);
    chk("rst_rv3",    {31'b0, if3.RespValid},  32'd0);
    chk("rst_done3",  {31'b0, if3.InitDone},   32'd0);
  endtask

  // Called #1 after the edge where reset was released
  task automatic wait_init();
    int c0;
    c0 = cyc;
    while ((!if1.InitDone || !if3.InitDone) && (cyc - c0) < 200) begin
      @(posedge clk); #1;
    end
    chk("init_len", cyc - c0, DEPTH);
    chk("init_ready1", {31'b0, if1.ReqReady}, 32'd1);
    chk("init_ready3", {31'b0, if3.ReqReady}, 32'd1);
  endtask

  initial begin
    if1.ReqValid = 1'b0; if1.ReqWrite = 1'b0; if1.ReqSize = 2'b00; if1.ReqSigned = 1'b0;
    if1.Address = '0; if1.WriteData = '0;
    if3.ReqValid = 1'b0; if3.ReqWrite = 1'b0; if3.ReqSize = 2'b00; if3.ReqSigned = 1'b0;
    if3.Address = '0; if3.WriteData = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    idle(3);
    reset_checks();
    reset = 1'b0;
    wait_init();

    // READ_LAT = 1: basic load, store-then-load, extension
    ld(1, 2'b10, 1'b0, 7'd0, 32'h0000_0000);
    st(1, 2'b10, 7'd8, 32'h1234_5678);
    ld(1, 2'b00, 1'b1, 7'd9,  32'h0000_0056);
    ld(1, 2'b01, 1'b1, 7'd10, 32'h0000_1234);
    ld(1, 2'b10, 1'b0, 7'd8,  32'h1234_5678);
    st(1, 2'b00, 7'd11, 32'h0000_0080);
    ld(1, 2'b00, 1'b1, 7'd11, 32'hFFFF_FF80);
    ld(1, 2'b00, 1'b0, 7'd11, 32'h0000_0080);
    ld(1, 2'b10, 1'b0, 7'd8,  32'h8034_5678);
    st(1, 2'b01, 7'd12, 32'h0000_CAFE);
    ld(1, 2'b01, 1'b1, 7'd12, 32'hFFFF_CAFE);
    ld(1, 2'b01, 1'b0, 7'd12, 32'h0000_CAFE);
    st(1, 2'b01, 7'd14, 32'hFFFF_1111);
    ld(1, 2'b10, 1'b0, 7'd12, 32'h1111_CAFE);
    ld(1, 2'b00, 1'b1, 7'd13, 32'hFFFF_FFCA);
    ld(1, 2'b00, 1'b0, 7'd14, 32'h0000_0011);
    idle(2);

    // Misaligned / illegal: pulse only, no access
    st(1, 2'b10, 7'd4, 32'hDEAD_BEEF);
    bad(1, 1'b0, 2'b10, 7'd6, 32'h0);
    bad(1, 1'b1, 2'b01, 7'd5, 32'h0000_FFFF);
    bad(1, 1'b1, 2'b11, 7'd0, 32'hFFFF_FFFF);
    idle(1);
    bad(1, 1'b0, 2'b01, 7'd3, 32'h0);
    idle(1);
    ld(1, 2'b10, 1'b0, 7'd4, 32'hDEAD_BEEF);
    ld(1, 2'b10, 1'b0, 7'd0, 32'h0000_0000);
    idle(4);

    // READ_LAT = 3: pipelined loads, store behind an in-flight load
    st(3, 2'b10, 7'd0, 32'h1111_1111);
    st(3, 2'b10, 7'd4, 32'h2222_2222);
    st(3, 2'b10, 7'd8, 32'h3333_3333);
    ld(3, 2'b10, 1'b0, 7'd0, 32'h1111_1111);
    ld(3, 2'b10, 1'b0, 7'd4, 32'h2222_2222);
    ld(3, 2'b10, 1'b0, 7'd8, 32'h3333_3333);
    st(3, 2'b10, 7'd4, 32'hA5A5_A5A5);
    ld(3, 2'b10, 1'b0, 7'd4, 32'hA5A5_A5A5);
    ld(3, 2'b00, 1'b1, 7'd5, 32'hFFFF_FFA5);
    bad(3, 1'b0, 2'b10, 7'd2, 32'h0);
    idle(6);

    // Reset with a load in flight; requests held during INIT are ignored
    st(3, 2'b10, 7'd16, 32'h55AA_55AA);
    req(3, 1'b0, 2'b10, 1'b0, 7'd16, 32'h0, 1'b0, 1'b0, 32'h0);
    idle(1);
    reset = 1'b1;
    #1;
    reset_checks();
    if1.ReqValid = 1'b1; if1.ReqWrite = 1'b1; if1.ReqSize = 2'b10;
    if1.Address = 7'd0; if1.WriteData = 32'hFFFF_FFFF;
    idle(2);
    reset = 1'b0;
    wait_init();
    if1.ReqValid = 1'b0;
    ld(3, 2'b10, 1'b0, 7'd16, 32'h0000_0000);
    ld(1, 2'b10, 1'b0, 7'd0,  32'h0000_0000);
    ld(1, 2'b10, 1'b0, 7'd8,  32'h0000_0000);
    idle(8);

    while (rq1.size() > 0) begin void'(rq1.pop_front()); fail("resp1_left", 0, 1); end
    while (rq3.size() > 0) begin void'(rq3.pop_front()); fail("resp3_left", 0, 1); end
    while (mq1.size() > 0) begin void'(mq1.pop_front()); fail("mis1_left", 0, 1); end
    while (mq3.size() > 0) begin void'(mq3.pop_front()); fail("mis3_left", 0, 1); end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised data memory for the MIPS pipeline's MEM stage. It takes byte-addressed load/store requests (byte, halfword, word), with sign/zero extension on loads. It has a configurable read latency and a valid/ready request handshake, and it detects misaligned accesses. After every reset it runs a self-clearing pass so the array contents are deterministic in both synthesis and simulation.

## Interface
- DEPTH, 32, number of 32-bit words; must be a power of two, ≥ 4
- ADDR_W, $clog2(DEPTH)+2, byte-address width (derived, not overridden)
- READ_LAT, 1, cycles from read accept to RespValid; legal range 1..4
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- ReqValid  input  1  request present
- ReqReady  output  1  block can accept a request this cycle
- ReqWrite  input  1  1 = store, 0 = load
- ReqSize  input  2  00 byte, 01 halfword, 10 word, 11 illegal
- ReqSigned  input  1  loads only: 1 = sign-extend, 0 = zero-extend; ignored for word and for stores
- Address  input  ADDR_W  byte address; word index = Address[ADDR_W-1:2], lane = Address[1:0]
- WriteData  input  32  store data, right-justified (byte in [7:0], half in [15:0])
- RespValid  output  1  ReadData valid this cycle (one-cycle pulse per load)
- ReadData  output  32  extended load result
- Misaligned  output  1  one-cycle pulse: previous accepted request was misaligned/illegal
- InitDone  output  1  clearing pass complete

## Operation
- FSM states: INIT, IDLE. Reset → INIT; the only transition is INIT → IDLE.
- INIT:
  - InitIdx counts 0..DEPTH-1 and writes 32'h0 to Memory[InitIdx] each cycle.
  - On the cycle InitIdx = DEPTH-1 the state moves to IDLE and InitDone is set.
  - ReqReady = 0 throughout INIT.
- IDLE:
  - ReqReady = 1 every cycle; one request accepted per cycle when ReqValid & ReqReady.
- Alignment check:
  - Halfword: misaligned if Address[0] = 1.
  - Word: misaligned if Address[1:0] ≠ 0.
  - ReqSize = 11 is always illegal.
  - A misaligned or illegal request performs no memory access and no RespValid. Misaligned pulses 1 on the cycle after accept.
- Lanes are little-endian: lane k = bits [8k+7:8k].
- Store:
  - Byte writes WriteData[7:0] into lane k.
  - Halfword writes WriteData[15:0] into lanes k and k+1.
  - Word writes all lanes.
  - Unaddressed lanes are unchanged. The write commits on the accept edge. Stores produce no response.
- Load:
  - The word is sampled into read pipeline stage 1 on the accept edge, together with lane, size and signed.
  - Extraction and extension happen at the final stage.
  - Stores accepted after a load do not alter that in-flight load's result.
- Store at T, load of the same word accepted at T+1: the load returns the new data.
- ReadData holds its last value while RespValid = 0.

## Timing
- Reset values: ReqReady 0, RespValid 0, ReadData 0, Misaligned 0, InitDone 0, InitIdx 0, read pipeline valid bits 0.
- After reset deasserts, INIT lasts exactly DEPTH cycles. ReqReady and InitDone rise together at the end of INIT and stay high until the next reset.
- Load accepted at edge T gives RespValid high during cycle T+READ_LAT. Fully pipelined: N back-to-back loads give N consecutive RespValid pulses.
- Misaligned request accepted at edge T: Misaligned high during cycle T+1 only.
- Reset mid-operation:
  - In-flight loads are discarded (no RespValid).
  - Misaligned clears and InitDone clears.
  - INIT restarts from index 0 and all memory is re-cleared.
- ReqValid during INIT is ignored (not accepted, no side effects).

## Test plan
- Reset, wait DEPTH cycles → InitDone = 1 on cycle DEPTH. Word load at address 0 → RespValid after READ_LAT cycles, ReadData = 0x00000000.
- Store word 0x12345678 at address 8, then:
  - lb signed at 9 → 0x00000056
  - lh signed at 10 → 0x00001234
  - lw at 8 → 0x12345678
- Store byte 0x80 at address 11, then:
  - lb signed at 11 → 0xFFFFFF80
  - lbu at 11 → 0x00000080
  - lw at 8 → 0x80345678
- Word load at address 6, halfword store at 5, ReqSize = 11 at 0 → each gives a one-cycle Misaligned pulse, no RespValid, and lw at 4 is unchanged.
- READ_LAT = 3: loads at 0, 4, 8 on consecutive cycles, with a word store 0xA5A5A5A5 to 4 one cycle after its load → three consecutive RespValid pulses starting 3 cycles after the first accept. The address-4 load returns the old value.
- Load in flight (READ_LAT = 3) with reset asserted after 1 cycle → no RespValid, ReqReady low for DEPTH cycles. A previously stored nonzero word reads back 0x00000000 afterwards.
